alu_op_driver: RTL and testbench



---
 rtl/alu_pkg.sv | 18 +
 rtl/my_alu.sv | 30 +++
 rtl/alu_op_driver.sv | 98 +++++++++
 tb/tb_alu_op_driver.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU command path.
// Opcodes, datapath width and driver FSM encoding.
package alu_pkg;

  localparam int ALU_W = 8;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_DEC = 2'b10;
  localparam logic [1:0] ALU_OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } drv_state_e;

endpackage

// File: rtl/my_alu.sv
// Combinational 8-bit ALU: add, sub (borrow), dec(A), xor.
// Instantiated beside alu_op_driver, one level up.
module my_alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic [1:0]       select_i,
  output logic [ALU_W-1:0] s_o,
  output logic             c_o
);

  logic [ALU_W:0] wide;

  // Opcode decode; bit 8 carries carry or borrow
  always_comb begin
    wide = '0;
    unique case (select_i)
      ALU_OP_ADD: wide = {1'b0, a_i} + {1'b0, b_i};
      ALU_OP_SUB: wide = {1'b0, a_i} - {1'b0, b_i};
      ALU_OP_DEC: wide = {1'b0, a_i - 8'd1};
      ALU_OP_XOR: wide = {1'b0, a_i ^ b_i};
      default:    wide = '0;
    endcase
  end

  assign s_o = wide[ALU_W-1:0];
  assign c_o = wide[ALU_W];

endmodule

// File: rtl/alu_op_driver.sv
// Handshaked command front-end for my_alu.
// Optional accumulator: ALU_OP_DRIVER_ACC_EN.
module alu_op_driver
  import alu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [ALU_W-1:0] cmd_a_i,
  input  logic [ALU_W-1:0] cmd_b_i,
  input  logic [1:0]       cmd_op_i,
  input  logic             cmd_acc_i,
  output logic [ALU_W-1:0] alu_a_o,
  output logic [ALU_W-1:0] alu_b_o,
  output logic [1:0]       alu_select_o,
  input  logic [ALU_W-1:0] alu_s_i,
  input  logic             alu_c_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [ALU_W-1:0] res_s_o,
  output logic             res_c_o,
  output logic             res_z_o,
  output logic [7:0]       op_cnt_o
);

  drv_state_e       state;
  logic [ALU_W-1:0] a_src;

`ifdef ALU_OP_DRIVER_ACC_EN
  logic [ALU_W-1:0] acc;

  assign a_src = cmd_acc_i ? acc : cmd_a_i;

  // Accumulator follows every captured result
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      acc <= '0;
    end else if (state == EXEC) begin
      acc <= alu_s_i;
    end
  end
`else
  logic acc_unused;

  assign acc_unused = cmd_acc_i;
  assign a_src      = cmd_a_i;
`endif

  // Command/result FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      cmd_ready_o  <= 1'b1;
      res_valid_o  <= 1'b0;
      alu_a_o      <= '0;
      alu_b_o      <= '0;
      alu_select_o <= '0;
      res_s_o      <= '0;
      res_c_o      <= 1'b0;
      res_z_o      <= 1'b0;
      op_cnt_o     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            alu_a_o      <= a_src;
            alu_b_o      <= cmd_b_i;
            alu_select_o <= cmd_op_i;
            cmd_ready_o  <= 1'b0;
            state        <= EXEC;
          end
        end
        EXEC: begin
          res_s_o     <= alu_s_i;
          res_c_o     <= alu_c_i;
          res_z_o     <= (alu_s_i == '0);
          res_valid_o <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            op_cnt_o    <= op_cnt_o + 8'd1;
            state       <= IDLE;
          end
        end
        default: begin
          res_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver wired to my_alu.
// Scoreboard of expected results, popped on result handshake.
module tb_alu_op_driver;
  import alu_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [7:0] cmd_a_i;
  logic [7:0] cmd_b_i;
  logic [1:0] cmd_op_i;
  logic       cmd_acc_i;
  logic [7:0] alu_a_o;
  logic [7:0] alu_b_o;
  logic [1:0] alu_select_o;
  logic [7:0] alu_s;
  logic       alu_c;
  logic       res_valid_o;
  logic       res_ready_i;
  logic [7:0] res_s_o;
  logic       res_c_o;
  logic       res_z_o;
  logic [7:0] op_cnt_o;

  alu_op_driver dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_a_i      (cmd_a_i),
    .cmd_b_i      (cmd_b_i),
    .cmd_op_i     (cmd_op_i),
    .cmd_acc_i    (cmd_acc_i),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_select_o (alu_select_o),
    .alu_s_i      (alu_s),
    .alu_c_i      (alu_c),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_s_o      (res_s_o),
    .res_c_o      (res_c_o),
    .res_z_o      (res_z_o),
    .op_cnt_o     (op_cnt_o)
  );

  my_alu u_alu (
    .a_i      (alu_a_o),
    .b_i      (alu_b_o),
    .select_i (alu_select_o),
    .s_o      (alu_s),
    .c_o      (alu_c)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [9:0] exp_q[$];
  int         acc_cyc[$];
  logic [7:0] acc_m = 8'h00;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {z, c, s}
  function automatic logic [9:0] model(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [1:0] op);
    logic [8:0] w;
    case (op)
      2'b00:   w = {1'b0, a} + {1'b0, b};
      2'b01:   w = {1'b0, a} - {1'b0, b};
      2'b10:   w = {1'b0, a - 8'd1};
      default: w = {1'b0, a ^ b};
    endcase
    return {(w[7:0] == 8'h00), w};
  endfunction

  always @(posedge clk_i) cyc++;

  // Scoreboard: push on accept, pop on result handshake
  always @(negedge clk_i) begin
    logic [7:0] a_eff;
    logic [9:0] e;
    if (!rst_n_i) begin
      exp_q.delete();
      acc_m = 8'h00;
    end else begin
      if (res_valid_o && res_ready_i) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_s", res_s_o, e[7:0]);
          check("sb_c", res_c_o, e[8]);
          check("sb_z", res_z_o, e[9]);
        end
      end
      if (cmd_valid_i && cmd_ready_o) begin
        a_eff = cmd_a_i;
`ifdef ALU_OP_DRIVER_ACC_EN
        if (cmd_acc_i) a_eff = acc_m;
`endif
        e = model(a_eff, cmd_b_i, cmd_op_i);
        acc_m = e[7:0];
        exp_q.push_back(e);
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int g = 0;
    while (!cmd_ready_o && g < 20) begin
      step();
      g++;
    end
    if (!cmd_ready_o) check(tag, 0, 1);
  endtask

  task automatic wait_res(input string tag);
    int g = 0;
    while (!res_valid_o && g < 20) begin
      step();
      g++;
    end
    if (!res_valid_o) check(tag, 0, 1);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic acc);
    cmd_a_i     = a;
    cmd_b_i     = b;
    cmd_op_i    = op;
    cmd_acc_i   = acc;
    cmd_valid_i = 1'b1;
    wait_ready("do_op_ready_timeout");
    step();
    cmd_valid_i = 1'b0;
    res_ready_i = 1'b1;
    wait_res("do_op_res_timeout");
    step();
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    step();
    step();
    rst_n_i = 1'b1;
  endtask

  initial begin
    logic [7:0] hold_s;
    rst_n_i     = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_a_i     = '0;
    cmd_b_i     = '0;
    cmd_op_i    = '0;
    cmd_acc_i   = 1'b0;
    res_ready_i = 1'b0;
    step();
    step();
    rst_n_i = 1'b1;

    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_res_s", res_s_o, 0);
    check("rst_alu_a", alu_a_o, 0);
    check("rst_op_cnt", op_cnt_o, 0);

    // Add with carry, one-cycle valid
    cmd_a_i     = 8'hF0;
    cmd_b_i     = 8'h20;
    cmd_op_i    = ALU_OP_ADD;
    cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    check("add_alu_a", alu_a_o, 8'hF0);
    check("add_alu_b", alu_b_o, 8'h20);
    check("add_ready_exec", cmd_ready_o, 0);
    check("add_valid_exec", res_valid_o, 0);
    step();
    check("add_valid", res_valid_o, 1);
    check("add_s", res_s_o, 8'h10);
    check("add_c", res_c_o, 1);
    check("add_z", res_z_o, 0);
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    check("add_cnt", op_cnt_o, 1);
    check("add_idle", cmd_ready_o, 1);

    // Xor to zero under back-pressure
    cmd_a_i     = 8'h5A;
    cmd_b_i     = 8'h5A;
    cmd_op_i    = ALU_OP_XOR;
    cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", res_valid_o, 1);
      check("bp_s", res_s_o, 8'h00);
      check("bp_z", res_z_o, 1);
      check("bp_c", res_c_o, 0);
      check("bp_ready", cmd_ready_o, 0);
      step();
    end
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    check("bp_cnt", op_cnt_o, 2);
    check("bp_idle", cmd_ready_o, 1);
    check("bp_done", res_valid_o, 0);

    // Back-to-back throughput from a fresh counter
    do_reset();
    acc_cyc.delete();
    res_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin cmd_a_i = 8'h12; cmd_b_i = 8'h34; end
        1: begin cmd_a_i = 8'h05; cmd_b_i = 8'h03; end
        2: begin cmd_a_i = 8'h01; cmd_b_i = 8'h77; end
        default: begin cmd_a_i = 8'h3C; cmd_b_i = 8'h0F; end
      endcase
      cmd_op_i    = 2'(k);
      cmd_valid_i = 1'b1;
      wait_ready("b2b_ready_timeout");
      step();
    end
    cmd_valid_i = 1'b0;
    wait_res("b2b_res_timeout");
    step();
    check("b2b_s_last", res_s_o, 8'h33);
    check("b2b_cnt", op_cnt_o, 4);
    check("b2b_accepts", acc_cyc.size(), 4);
    for (int k = 1; k < acc_cyc.size(); k++)
      check("b2b_spacing", acc_cyc[k] - acc_cyc[k-1], 3);

    // Counter wrap
    while (op_cnt_o != 8'hFF) begin
      do_op(8'($urandom), 8'($urandom), 2'($urandom), 1'b0);
      if (cyc > 5000) break;
    end
    check("wrap_ff", op_cnt_o, 8'hFF);
    do_op(8'h05, 8'h09, ALU_OP_SUB, 1'b0);
    check("wrap_00", op_cnt_o, 8'h00);
    check("wrap_borrow", res_c_o, 1);

    // Reset while in EXEC
    res_ready_i = 1'b0;
    cmd_a_i     = 8'hAA;
    cmd_b_i     = 8'h11;
    cmd_op_i    = ALU_OP_ADD;
    cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    hold_s = alu_a_o;
    check("mid_alu_a", hold_s, 8'hAA);
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    check("mid_ready", cmd_ready_o, 1);
    check("mid_valid", res_valid_o, 0);
    check("mid_alu_a0", alu_a_o, 0);
    check("mid_alu_b0", alu_b_o, 0);
    check("mid_res_s0", res_s_o, 0);
    check("mid_res_c0", res_c_o, 0);
    check("mid_cnt", op_cnt_o, 0);
    step();
    step();
    check("mid_no_result", res_valid_o, 0);

    // Accumulator chaining
    do_op(8'h10, 8'h01, ALU_OP_ADD, 1'b0);
    check("acc_first", res_s_o, 8'h11);
    do_op(8'hFF, 8'h01, ALU_OP_ADD, 1'b1);
`ifdef ALU_OP_DRIVER_ACC_EN
    check("acc_chain_s", res_s_o, 8'h12);
    check("acc_chain_c", res_c_o, 0);
`else
    check("acc_chain_s", res_s_o, 8'h00);
    check("acc_chain_c", res_c_o, 1);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
